// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the EX/MEM input, the data-memory port, the
// forwarding tap and the MEM/WB outputs of the LC-3b MEM stage.
//   slave  : the MEM stage itself
//   master : whatever drives the stage (EX/MEM register, memory, testbench)
interface mem_stage_if;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [15:0] in_addr;
    logic [15:0] in_result;
    logic [15:0] in_store_data;
    logic [3:0]  in_destreg;
    logic        stall_o;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_en;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic [3:0]  ex_fwd_destreg;
    logic [15:0] ex_fwd_data;
    logic        wb_valid;
    logic [3:0]  wb_destreg;
    logic [15:0] wb_data;

    modport slave (
        input  in_valid, in_op, in_addr, in_result, in_store_data, in_destreg,
        input  dmem_rdata, dmem_resp,
        output stall_o, dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_en,
        output ex_fwd_destreg, ex_fwd_data,
        output wb_valid, wb_destreg, wb_data
    );

    modport master (
        output in_valid, in_op, in_addr, in_result, in_store_data, in_destreg,
        output dmem_rdata, dmem_resp,
        input  stall_o, dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_en,
        input  ex_fwd_destreg, ex_fwd_data,
        input  wb_valid, wb_destreg, wb_data
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the LC-3b datapath.
// Performs LDR/STR/LDB/STB as one data-memory access and LDI/STI as two
// (pointer fetch, then the real access). Upstream is stalled until the
// access completes; the MEM/WB register captures the retiring result.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous active-high reset
//   bus    mem_stage_if.slave: EX/MEM inputs, data-memory port,
//          EX/MEM forwarding tap, MEM/WB outputs
//
// state | meaning
// IDLE  | first (or only) access of the instruction, or pass-through
// IND   | LDI/STI second access using the fetched pointer in ind_addr
module mem_stage #(
    parameter logic [3:0] NOREG = 4'b1000
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, IND = 1'b1} state_t;

    localparam logic [2:0] OP_LDR = 3'd1;
    localparam logic [2:0] OP_STR = 3'd2;
    localparam logic [2:0] OP_LDB = 3'd3;
    localparam logic [2:0] OP_STB = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_STI = 3'd6;

    state_t      state, state_nxt;
    logic [15:0] ind_addr;
    logic        rd, wr, stall, ind_capture, complete;
    logic [15:0] addr, wdata;
    logic [1:0]  be;
    logic        is_none, is_store;
    logic [7:0]  ldb_byte;
    logic        wb_valid_q;
    logic [3:0]  wb_destreg_q;
    logic [15:0] wb_data_q;

    always_comb begin
        is_none  = !(bus.in_op inside {OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI});
        is_store = (bus.in_op == OP_STR) || (bus.in_op == OP_STB) || (bus.in_op == OP_STI);
        ldb_byte = bus.in_addr[0] ? bus.dmem_rdata[15:8] : bus.dmem_rdata[7:0];
    end

    // Requests are Mealy: the response in the same cycle releases the stall.
    always_comb begin
        state_nxt   = state;
        rd          = 1'b0;
        wr          = 1'b0;
        addr        = 16'h0000;
        wdata       = 16'h0000;
        be          = 2'b00;
        stall       = 1'b0;
        ind_capture = 1'b0;
        if (!reset && bus.in_valid) begin
            case (state)
                IDLE: begin
                    case (bus.in_op)
                        OP_LDR, OP_LDB: begin
                            rd    = 1'b1;
                            addr  = {bus.in_addr[15:1], 1'b0};
                            stall = !bus.dmem_resp;
                        end
                        OP_STR: begin
                            wr    = 1'b1;
                            addr  = {bus.in_addr[15:1], 1'b0};
                            wdata = bus.in_store_data;
                            be    = 2'b11;
                            stall = !bus.dmem_resp;
                        end
                        OP_STB: begin
                            wr    = 1'b1;
                            addr  = {bus.in_addr[15:1], 1'b0};
                            wdata = {bus.in_store_data[7:0], bus.in_store_data[7:0]};
                            be    = bus.in_addr[0] ? 2'b10 : 2'b01;
                            stall = !bus.dmem_resp;
                        end
                        OP_LDI, OP_STI: begin
                            // pointer fetch never completes the instruction
                            rd    = 1'b1;
                            addr  = {bus.in_addr[15:1], 1'b0};
                            stall = 1'b1;
                            if (bus.dmem_resp) begin
                                ind_capture = 1'b1;
                                state_nxt   = IND;
                            end
                        end
                        default: ;
                    endcase
                end
                default: begin
                    case (bus.in_op)
                        OP_LDI: begin
                            rd    = 1'b1;
                            addr  = {ind_addr[15:1], 1'b0};
                            stall = !bus.dmem_resp;
                            if (bus.dmem_resp) state_nxt = IDLE;
                        end
                        OP_STI: begin
                            wr    = 1'b1;
                            addr  = {ind_addr[15:1], 1'b0};
                            wdata = bus.in_store_data;
                            be    = 2'b11;
                            stall = !bus.dmem_resp;
                            if (bus.dmem_resp) state_nxt = IDLE;
                        end
                        default: begin
                            // op changed under a stall: restart it from IDLE
                            stall     = 1'b1;
                            state_nxt = IDLE;
                        end
                    endcase
                end
            endcase
        end else if (!reset && state == IND) begin
            state_nxt = IDLE;
        end
    end

    assign complete = bus.in_valid && !stall && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ind_addr     <= 16'h0000;
            wb_valid_q   <= 1'b0;
            wb_destreg_q <= NOREG;
            wb_data_q    <= 16'h0000;
        end else begin
            state      <= state_nxt;
            wb_valid_q <= complete;
            if (ind_capture) ind_addr <= bus.dmem_rdata;
            if (complete) begin
                wb_destreg_q <= is_store ? NOREG : bus.in_destreg;
                case (bus.in_op)
                    OP_LDR, OP_LDI:         wb_data_q <= bus.dmem_rdata;
                    OP_LDB:                 wb_data_q <= {{8{ldb_byte[7]}}, ldb_byte};
                    OP_STR, OP_STB, OP_STI: wb_data_q <= wb_data_q;
                    default:                wb_data_q <= bus.in_result;
                endcase
            end else begin
                wb_destreg_q <= NOREG;
            end
        end
    end

    assign bus.stall_o        = stall;
    assign bus.dmem_read      = rd;
    assign bus.dmem_write     = wr;
    assign bus.dmem_addr      = addr;
    assign bus.dmem_wdata     = wdata;
    assign bus.dmem_byte_en   = be;
    assign bus.ex_fwd_destreg = (bus.in_valid && is_none) ? bus.in_destreg : NOREG;
    assign bus.ex_fwd_data    = bus.in_result;
    assign bus.wb_valid       = wb_valid_q;
    assign bus.wb_destreg     = wb_destreg_q;
    assign bus.wb_data        = wb_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. A small word memory plus
// per-instruction timelines give the expected strobes, stalls and MEM/WB
// contents for every cycle; a negedge process compares them.
module tb_mem_stage;
    localparam logic [3:0] NOREG = 4'b1000;
    localparam logic [2:0] OP_NONE = 3'd0, OP_LDR = 3'd1, OP_STR = 3'd2, OP_LDB = 3'd3,
                           OP_STB = 3'd4, OP_LDI = 3'd5, OP_STI = 3'd6, OP_X7 = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if ifc();
    mem_stage dut (.clk(clk), .reset(reset), .bus(ifc));

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [logic [15:0]];

    logic        chk_en = 1'b0, wb_known = 1'b0;
    logic        exp_read = 1'b0, exp_write = 1'b0, exp_stall = 1'b0;
    logic [15:0] exp_addr = '0, exp_wdata = '0, exp_fwd_data = '0, exp_wb_data = '0;
    logic [1:0]  exp_be = '0;
    logic [3:0]  exp_fwd_dest = NOREG, exp_wb_dest = NOREG;
    logic        exp_wb_valid = 1'b0;
    logic        pend_valid = 1'b0, pend_load = 1'b0, pend_known = 1'b0;
    logic [3:0]  pend_dest = NOREG;
    logic [15:0] pend_data = '0;

    logic [15:0] last_rd_addr = '0, last_wr_data = '0;
    logic [1:0]  last_wr_be = '0;
    int          stall_cnt = 0, wb_run = 0, wb_run_max = 0;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("stall_o", 16'(ifc.stall_o), 16'(exp_stall));
            cmp("dmem_read", 16'(ifc.dmem_read), 16'(exp_read));
            cmp("dmem_write", 16'(ifc.dmem_write), 16'(exp_write));
            if (exp_read || exp_write) cmp("dmem_addr", ifc.dmem_addr, exp_addr);
            if (exp_write) begin
                cmp("dmem_wdata", ifc.dmem_wdata, exp_wdata);
                cmp("dmem_byte_en", 16'(ifc.dmem_byte_en), 16'(exp_be));
            end
            cmp("ex_fwd_destreg", 16'(ifc.ex_fwd_destreg), 16'(exp_fwd_dest));
            cmp("ex_fwd_data", ifc.ex_fwd_data, exp_fwd_data);
            if (wb_known) begin
                cmp("wb_valid", 16'(ifc.wb_valid), 16'(exp_wb_valid));
                cmp("wb_destreg", 16'(ifc.wb_destreg), 16'(exp_wb_dest));
                cmp("wb_data", ifc.wb_data, exp_wb_data);
            end
            if (ifc.dmem_read) last_rd_addr = ifc.dmem_addr;
            if (ifc.dmem_write) begin
                last_wr_data = ifc.dmem_wdata;
                last_wr_be   = ifc.dmem_byte_en;
            end
            if (ifc.stall_o) stall_cnt++;
            wb_run = ifc.wb_valid ? wb_run + 1 : 0;
            if (wb_run > wb_run_max) wb_run_max = wb_run;
        end
    end

    function automatic logic [15:0] mrd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // One clock cycle: drive inputs, state what this cycle must show, and
    // what the following edge must leave in MEM/WB.
    task automatic step(input logic rst, input logic v, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] r, input logic [15:0] sd,
                        input logic [3:0] d, input logic rsp, input logic [15:0] rdat,
                        input logic e_rd, input logic e_wr, input logic [15:0] e_addr,
                        input logic [15:0] e_wd, input logic [1:0] e_be, input logic e_stall,
                        input logic ret, input logic [3:0] ret_dest, input logic ret_load,
                        input logic [15:0] ret_data);
        exp_wb_valid = pend_valid;
        exp_wb_dest  = pend_dest;
        if (pend_load) exp_wb_data = pend_data;
        if (pend_known) wb_known = 1'b1;
        reset             = rst;
        ifc.in_valid      = v;
        ifc.in_op         = op;
        ifc.in_addr       = a;
        ifc.in_result     = r;
        ifc.in_store_data = sd;
        ifc.in_destreg    = d;
        ifc.dmem_resp     = rsp;
        ifc.dmem_rdata    = rdat;
        exp_read     = !rst && e_rd;
        exp_write    = !rst && e_wr;
        exp_addr     = e_addr;
        exp_wdata    = e_wd;
        exp_be       = e_be;
        exp_stall    = !rst && e_stall;
        exp_fwd_dest = (v && (op == OP_NONE || op == OP_X7)) ? d : NOREG;
        exp_fwd_data = r;
        if (rst) begin
            pend_valid = 1'b0; pend_dest = NOREG; pend_load = 1'b1; pend_data = '0; pend_known = 1'b1;
        end else begin
            pend_valid = ret;
            pend_dest  = ret ? ret_dest : NOREG;
            pend_load  = ret && ret_load;
            pend_data  = ret_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bubble(input logic rsp);
        step(1'b0, 1'b0, OP_NONE, '0, '0, '0, NOREG, rsp, 16'h1111,
             1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, NOREG, 1'b0, '0);
    endtask

    // For NONE-class ops, w1 != 0 pulses a stray dmem_resp that must be ignored.
    task automatic run_instr(input logic [2:0] op, input logic [15:0] a, input logic [15:0] r,
                             input logic [15:0] sd, input logic [3:0] d, input int w1, input int w2);
        logic [15:0] wa, m, ptr, pm, ld, wd;
        logic [7:0]  byt;
        logic [1:0]  be;
        logic        store, isrd;
        wa    = {a[15:1], 1'b0};
        store = (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
        case (op)
            OP_LDR, OP_STR, OP_LDB, OP_STB: begin
                m    = mrd(wa);
                byt  = a[0] ? m[15:8] : m[7:0];
                ld   = (op == OP_LDB) ? {{8{byt[7]}}, byt} : m;
                be   = (op == OP_STR) ? 2'b11 : (op == OP_STB) ? (a[0] ? 2'b10 : 2'b01) : 2'b00;
                wd   = (op == OP_STB) ? {sd[7:0], sd[7:0]} : (op == OP_STR) ? sd : 16'h0000;
                isrd = (op == OP_LDR) || (op == OP_LDB);
                for (int i = 0; i <= w1; i++)
                    step(1'b0, 1'b1, op, a, r, sd, d, i == w1, (i == w1) ? m : 16'($urandom),
                         isrd, !isrd, wa, wd, be, i != w1, i == w1,
                         store ? NOREG : d, !store, ld);
                if (op == OP_STR) mem[wa] = sd;
                if (op == OP_STB) mem[wa] = a[0] ? {sd[7:0], m[7:0]} : {m[15:8], sd[7:0]};
            end
            OP_LDI, OP_STI: begin
                m = mrd(wa);
                for (int i = 0; i <= w1; i++)
                    step(1'b0, 1'b1, op, a, r, sd, d, i == w1, (i == w1) ? m : 16'($urandom),
                         1'b1, 1'b0, wa, '0, '0, 1'b1, 1'b0, NOREG, 1'b0, '0);
                ptr = {m[15:1], 1'b0};
                pm  = mrd(ptr);
                for (int j = 0; j <= w2; j++)
                    step(1'b0, 1'b1, op, a, r, sd, d, j == w2, (j == w2) ? pm : 16'($urandom),
                         op == OP_LDI, op == OP_STI, ptr, (op == OP_STI) ? sd : 16'h0000,
                         (op == OP_STI) ? 2'b11 : 2'b00, j != w2, j == w2,
                         store ? NOREG : d, !store, pm);
                if (op == OP_STI) mem[ptr] = sd;
            end
            default:
                step(1'b0, 1'b1, op, a, r, sd, d, w1 != 0, 16'hF00D,
                     1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, d, 1'b1, r);
        endcase
    endtask

    initial begin
        ifc.in_valid = 1'b0; ifc.in_op = '0; ifc.in_addr = '0; ifc.in_result = '0;
        ifc.in_store_data = '0; ifc.in_destreg = NOREG; ifc.dmem_resp = 1'b0; ifc.dmem_rdata = '0;
        mem[16'h0040] = 16'hBEEF;
        mem[16'h0100] = 16'h80FF;
        mem[16'h0010] = 16'h0300;
        mem[16'h0300] = 16'h5555;
        mem[16'h0020] = 16'h0401;
        mem[16'h0400] = 16'h1357;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // reset, with a stray response that must not matter
        step(1'b1, 1'b1, OP_LDR, 16'h0040, '0, '0, 4'd1, 1'b1, 16'h9999,
             1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, NOREG, 1'b0, '0);
        step(1'b1, 1'b0, OP_NONE, '0, '0, '0, NOREG, 1'b0, '0,
             1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, NOREG, 1'b0, '0);
        cmp("reset_wb_valid", 16'(ifc.wb_valid), 16'h0000);
        cmp("reset_wb_destreg", 16'(ifc.wb_destreg), 16'(NOREG));
        cmp("reset_wb_data", ifc.wb_data, 16'h0000);

        // 1: pass-through
        run_instr(OP_NONE, 16'h7777, 16'h1234, 16'h0000, 4'd3, 0, 0);
        cmp("t1_wb_valid", 16'(ifc.wb_valid), 16'h0001);
        cmp("t1_wb_destreg", 16'(ifc.wb_destreg), 16'h0003);
        cmp("t1_wb_data", ifc.wb_data, 16'h1234);
        bubble(1'b1);

        // 2: LDR with three wait cycles, odd address
        stall_cnt = 0;
        run_instr(OP_LDR, 16'h0041, 16'h0041, 16'h0000, 4'd5, 3, 0);
        cmp("t2_dmem_addr", last_rd_addr, 16'h0040);
        cmp("t2_stall_cycles", 16'(stall_cnt), 16'd3);
        cmp("t2_wb_data", ifc.wb_data, 16'hBEEF);

        // 3: byte load and byte store, both lanes
        run_instr(OP_LDB, 16'h0101, 16'h0101, 16'h0000, 4'd2, 1, 0);
        cmp("t3_ldb_hi", ifc.wb_data, 16'hFF80);
        run_instr(OP_LDB, 16'h0100, 16'h0100, 16'h0000, 4'd4, 0, 0);
        cmp("t3_ldb_lo", ifc.wb_data, 16'hFFFF);
        run_instr(OP_STB, 16'h0101, 16'h0101, 16'h00AB, 4'd6, 2, 0);
        cmp("t3_stb_be", 16'(last_wr_be), 16'h0002);
        cmp("t3_stb_wdata", last_wr_data, 16'hABAB);
        cmp("t3_stb_destreg", 16'(ifc.wb_destreg), 16'(NOREG));
        run_instr(OP_STB, 16'h0200, 16'h0200, 16'h1234, 4'd6, 0, 0);
        cmp("t3_stb_be_lo", 16'(last_wr_be), 16'h0001);
        run_instr(OP_STR, 16'h0201, 16'h0201, 16'h5A5A, 4'd1, 1, 0);
        run_instr(OP_LDR, 16'h0200, 16'h0200, 16'h0000, 4'd7, 0, 0);
        cmp("t3_ldr_after_str", ifc.wb_data, 16'h5A5A);

        // 4: indirect loads and store
        run_instr(OP_LDI, 16'h0010, 16'h0010, 16'h0000, 4'd1, 2, 1);
        cmp("t4_ind_addr", last_rd_addr, 16'h0300);
        cmp("t4_wb_data", ifc.wb_data, 16'h5555);
        run_instr(OP_LDI, 16'h0021, 16'h0021, 16'h0000, 4'd2, 0, 0);
        cmp("t4_ldi_odd_ptr", ifc.wb_data, 16'h1357);
        run_instr(OP_STI, 16'h0010, 16'h0010, 16'hC0DE, 4'd3, 1, 2);
        run_instr(OP_LDR, 16'h0300, 16'h0300, 16'h0000, 4'd4, 0, 0);
        cmp("t4_sti_landed", ifc.wb_data, 16'hC0DE);

        // stray responses and op 7 treated as pass-through
        run_instr(OP_X7, 16'h0000, 16'hA5A5, 16'h0000, 4'd7, 1, 0);
        bubble(1'b1);

        // 5: reset while STI waits in IND; afterwards the held STI restarts its pointer fetch
        step(1'b0, 1'b1, OP_STI, 16'h0030, 16'h0030, 16'h7777, 4'd5, 1'b1, 16'h0500,
             1'b1, 1'b0, 16'h0030, '0, '0, 1'b1, 1'b0, NOREG, 1'b0, '0);
        step(1'b0, 1'b1, OP_STI, 16'h0030, 16'h0030, 16'h7777, 4'd5, 1'b0, 16'h2222,
             1'b0, 1'b1, 16'h0500, 16'h7777, 2'b11, 1'b1, 1'b0, NOREG, 1'b0, '0);
        step(1'b1, 1'b1, OP_STI, 16'h0030, 16'h0030, 16'h7777, 4'd5, 1'b0, 16'h2222,
             1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, NOREG, 1'b0, '0);
        step(1'b0, 1'b1, OP_STI, 16'h0030, 16'h0030, 16'h7777, 4'd5, 1'b0, 16'h2222,
             1'b1, 1'b0, 16'h0030, '0, '0, 1'b1, 1'b0, NOREG, 1'b0, '0);
        cmp("t5_wb_valid", 16'(ifc.wb_valid), 16'h0000);
        cmp("t5_wb_destreg", 16'(ifc.wb_destreg), 16'(NOREG));
        cmp("t5_wb_data", ifc.wb_data, 16'h0000);
        bubble(1'b0);

        // 6: back-to-back NONE, LDR (zero wait), NONE
        bubble(1'b0);
        wb_run_max = 0;
        run_instr(OP_NONE, 16'h0000, 16'h0101, 16'h0000, 4'd1, 0, 0);
        run_instr(OP_LDR, 16'h0040, 16'h0040, 16'h0000, 4'd2, 0, 0);
        run_instr(OP_NONE, 16'h0000, 16'h0303, 16'h0000, 4'd3, 0, 0);
        bubble(1'b0);
        bubble(1'b0);
        cmp("t6_wb_run", 16'(wb_run_max), 16'd3);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
